csr_regfile: RTL and testbench
==============================

Name: csr_regfile

Overview:
- Machine-mode CSR register file and trap sequencer. It is the consumer at the far end of the CSR execution unit's write-back path.
- It takes each CSR write-back beat: new CSR value, CSR address, ecall flag, mret flag and instruction PC.
- It updates architectural CSR state, sequences ecall/mret control-flow redirects, and serves combinational CSR reads to issue.
- It runs in the synchronous core domain; the asynchronous-to-sync bridge sits upstream.

Parameters:
- P_MTVEC_RESET, 32'h0000_0000, reset value of mtvec.
- P_HARTID, 32'h0000_0000, value returned by mhartid.
- P_MISA, 32'h4000_0100, value returned by misa (RV32I).

Ports:
- clk  input  1  core clock; all state changes on rising edge.
- rstn  input  1  asynchronous active-low reset.
- i_wvalid  input  1  write-back beat valid.
- o_wready  output  1  beat accepted when i_wvalid & o_wready.
- i_waddr_12  input  12  target CSR address.
- i_wdata_32  input  32  new CSR value (csr_eu result).
- i_isEnv_1  input  1  beat is ecall.
- i_isMret_1  input  1  beat is mret.
- i_pc_32  input  32  PC of the instruction in the beat.
- i_retire_1  input  1  one instruction retired this cycle.
- i_raddr_12  input  12  read address from issue.
- o_rdata_32  output  32  combinational read data.
- o_rillegal_1  output  1  i_raddr_12 unmapped.
- o_illegalWrite_1  output  1  one-cycle pulse: accepted write hit an unmapped or read-only CSR.
- o_redirectValid_1  output  1  redirect request pending.
- i_redirectReady_1  input  1  front end takes the redirect.
- o_redirectPc_32  output  32  redirect target.

Behaviour:
- Reset (async, immediate): all CSRs reset to 0 except mtvec=P_MTVEC_RESET. FSM goes to IDLE. o_redirectValid_1=0, o_redirectPc_32=0, o_illegalWrite_1=0.
- CSR map: mstatus 0x300 (only MIE[3] and MPIE[7] writable; MPP[12:11] reads 2'b11; other bits read 0); misa 0x301 RO; mie 0x304; mtvec 0x305 (bits[1:0] forced 0); mscratch 0x340; mepc 0x341 (bits[1:0] forced 0); mcause 0x342; mtval 0x343; mip 0x344 RO reads 0; mcycle/mcycleh 0xB00/0xB80; minstret/minstreth 0xB02/0xB82; cycle/cycleh 0xC00/0xC80 RO aliases; instret/instreth 0xC02/0xC82 RO aliases; mhartid 0xF14 RO.
- Read port: purely combinational. Unmapped address gives o_rdata_32=0 and o_rillegal_1=1.
- FSM has two states, IDLE and REDIRECT. o_wready = (state==IDLE).
- Accepted beat priority: mret, then ecall, then plain write. The CSR write and ecall/mret are never combined; i_waddr_12/i_wdata_32 are ignored for env beats.
- Plain write: CSR updated at the accepting edge and visible on the read port in the next cycle. Unmapped or RO target: no state change, o_illegalWrite_1 pulses high for the cycle after the accept.
- Ecall at the accepting edge:
  - mepc<=i_pc_32, mcause<=32'd11, mtval<=0, MPIE<=MIE, MIE<=0.
  - o_redirectPc_32<=mtvec (pre-update value), go to REDIRECT.
- Mret at the accepting edge: MIE<=MPIE, MPIE<=1, o_redirectPc_32<=mepc, go to REDIRECT.
- REDIRECT: o_redirectValid_1=1 and o_redirectPc_32 stable. On a cycle with i_redirectReady_1=1, return to IDLE; valid drops next cycle and o_wready rises next cycle. Minimum spacing between two env beats is 2 cycles.
- mcycle: 64-bit, increments every cycle and wraps at 2^64-1 to 0.
  - A write to the low or high half replaces that half at that edge.
  - The other half holds: no increment and no carry that cycle.
- minstret: 64-bit, increments when i_retire_1=1.
  - A write to either half takes precedence over the retire increment in the same cycle; the other half holds.
- Reset during REDIRECT: returns to IDLE with valid=0; the pending redirect is dropped.
- i_wvalid while in REDIRECT: not accepted; the beat must be held upstream.

Test Plan:
- Reset with P_MTVEC_RESET=32'h0000_0100 -> read 0x305=32'h0000_0100; read 0x300=32'h0000_1800; o_redirectValid_1=0; o_wready=1.
- Write 0x340 with 32'hDEAD_BEEF, then read next cycle -> 32'hDEAD_BEEF. Write 0x341 with 32'h1235 -> reads 32'h1234.
- mstatus=32'h8 (MIE=1), mtvec=32'h80, ecall with pc=32'h200 -> redirect valid, target 32'h80; mepc=32'h200, mcause=11, mstatus=32'h1880. Hold i_redirectReady_1=0 for 3 cycles -> o_wready=0 throughout; assert ready -> IDLE next cycle.
- Mret after the above -> target 32'h200; mstatus=32'h1888 (MIE=1, MPIE=1).
- Write mcycle low half with 32'hFFFF_FFFF, high half=0, let it run 1 cycle -> mcycleh=1 and mcycle=0. Write minstret with 32'h5 while i_retire_1=1 -> reads 5, then 6 on the next retire.
- Write to 0x301 and to 0x7C0 -> no change; o_illegalWrite_1 one-cycle pulse for each; read 0x7C0 -> o_rillegal_1=1, data 0.

Source files
------------

// File: rtl/csr_regfile.sv
// Machine-mode CSR register file with ecall/mret redirect sequencing.
// Consumes CSR write-back beats and serves combinational reads to issue.
module csr_regfile #(
    parameter logic [31:0] P_MTVEC_RESET = 32'h0000_0000,
    parameter logic [31:0] P_HARTID      = 32'h0000_0000,
    parameter logic [31:0] P_MISA        = 32'h4000_0100
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        i_wvalid,
    output logic        o_wready,
    input  logic [11:0] i_waddr_12,
    input  logic [31:0] i_wdata_32,
    input  logic        i_isEnv_1,
    input  logic        i_isMret_1,
    input  logic [31:0] i_pc_32,
    input  logic        i_retire_1,
    input  logic [11:0] i_raddr_12,
    output logic [31:0] o_rdata_32,
    output logic        o_rillegal_1,
    output logic        o_illegalWrite_1,
    output logic        o_redirectValid_1,
    input  logic        i_redirectReady_1,
    output logic [31:0] o_redirectPc_32
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_REDIR = 1'b1;

    logic [0:0]  r_state;
    logic        r_mie;
    logic        r_mpie;
    logic [31:0] r_mie_csr;
    logic [31:0] r_mtvec;
    logic [31:0] r_mscratch;
    logic [31:0] r_mepc;
    logic [31:0] r_mcause;
    logic [31:0] r_mtval;
    logic [63:0] r_mcycle;
    logic [63:0] r_minstret;
    logic        r_illw;
    logic [31:0] r_rpc;

    logic        w_acc;
    logic        w_mret;
    logic        w_ecall;
    logic        w_wr;
    logic        w_wlegal;
    logic [31:0] w_mstatus;

    assign o_wready          = (r_state == S_IDLE);
    assign o_redirectValid_1 = (r_state == S_REDIR);
    assign o_redirectPc_32   = r_rpc;
    assign o_illegalWrite_1  = r_illw;

    assign w_acc   = i_wvalid & o_wready;
    assign w_mret  = w_acc & i_isMret_1;
    assign w_ecall = w_acc & ~i_isMret_1 & i_isEnv_1;
    assign w_wr    = w_acc & ~i_isMret_1 & ~i_isEnv_1;

    assign w_mstatus = {19'd0, 2'b11, 3'd0, r_mpie, 3'd0, r_mie, 3'd0};

    always_comb begin
        w_wlegal = 1'b0;
        case (i_waddr_12)
            12'h300, 12'h304, 12'h305,
            12'h340, 12'h341, 12'h342, 12'h343,
            12'hB00, 12'hB80, 12'hB02, 12'hB82: w_wlegal = 1'b1;
            default: w_wlegal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_rpc   <= 32'd0;
        end else if (w_ecall) begin
            r_state <= S_REDIR;
            r_rpc   <= r_mtvec;
        end else if (w_mret) begin
            r_state <= S_REDIR;
            r_rpc   <= r_mepc;
        end else if (r_state == S_REDIR && i_redirectReady_1) begin
            r_state <= S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_mie      <= 1'b0;
            r_mpie     <= 1'b0;
            r_mie_csr  <= 32'd0;
            r_mtvec    <= P_MTVEC_RESET;
            r_mscratch <= 32'd0;
            r_mepc     <= 32'd0;
            r_mcause   <= 32'd0;
            r_mtval    <= 32'd0;
            r_illw     <= 1'b0;
        end else begin
            r_illw <= w_wr & ~w_wlegal;
            if (w_mret) begin
                r_mie  <= r_mpie;
                r_mpie <= 1'b1;
            end else if (w_ecall) begin
                r_mepc   <= i_pc_32 & 32'hFFFF_FFFC;
                r_mcause <= 32'd11;
                r_mtval  <= 32'd0;
                r_mpie   <= r_mie;
                r_mie    <= 1'b0;
            end else if (w_wr) begin
                case (i_waddr_12)
                    12'h300: begin
                        r_mie  <= i_wdata_32[3];
                        r_mpie <= i_wdata_32[7];
                    end
                    12'h304: r_mie_csr  <= i_wdata_32;
                    12'h305: r_mtvec    <= i_wdata_32 & 32'hFFFF_FFFC;
                    12'h340: r_mscratch <= i_wdata_32;
                    12'h341: r_mepc     <= i_wdata_32 & 32'hFFFF_FFFC;
                    12'h342: r_mcause   <= i_wdata_32;
                    12'h343: r_mtval    <= i_wdata_32;
                    default: ;
                endcase
            end
        end
    end

    // A half-write freezes the other half: no increment, no carry.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_mcycle   <= 64'd0;
            r_minstret <= 64'd0;
        end else begin
            if (w_wr && i_waddr_12 == 12'hB00)
                r_mcycle[31:0] <= i_wdata_32;
            else if (w_wr && i_waddr_12 == 12'hB80)
                r_mcycle[63:32] <= i_wdata_32;
            else
                r_mcycle <= r_mcycle + 64'd1;

            if (w_wr && i_waddr_12 == 12'hB02)
                r_minstret[31:0] <= i_wdata_32;
            else if (w_wr && i_waddr_12 == 12'hB82)
                r_minstret[63:32] <= i_wdata_32;
            else if (i_retire_1)
                r_minstret <= r_minstret + 64'd1;
        end
    end

    always_comb begin
        o_rdata_32   = 32'd0;
        o_rillegal_1 = 1'b0;
        case (i_raddr_12)
            12'h300: o_rdata_32 = w_mstatus;
            12'h301: o_rdata_32 = P_MISA;
            12'h304: o_rdata_32 = r_mie_csr;
            12'h305: o_rdata_32 = r_mtvec;
            12'h340: o_rdata_32 = r_mscratch;
            12'h341: o_rdata_32 = r_mepc;
            12'h342: o_rdata_32 = r_mcause;
            12'h343: o_rdata_32 = r_mtval;
            12'h344: o_rdata_32 = 32'd0;
            12'hB00, 12'hC00: o_rdata_32 = r_mcycle[31:0];
            12'hB80, 12'hC80: o_rdata_32 = r_mcycle[63:32];
            12'hB02, 12'hC02: o_rdata_32 = r_minstret[31:0];
            12'hB82, 12'hC82: o_rdata_32 = r_minstret[63:32];
            12'hF14: o_rdata_32 = P_HARTID;
            default: o_rillegal_1 = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_csr_regfile.sv
// Self-checking bench for csr_regfile: write table plus trap,
// counter and reset-during-redirect sequences.
module tb_csr_regfile;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        i_wvalid = 1'b0;
    logic        o_wready;
    logic [11:0] i_waddr_12 = '0;
    logic [31:0] i_wdata_32 = '0;
    logic        i_isEnv_1 = 1'b0;
    logic        i_isMret_1 = 1'b0;
    logic [31:0] i_pc_32 = '0;
    logic        i_retire_1 = 1'b0;
    logic [11:0] i_raddr_12 = '0;
    logic [31:0] o_rdata_32;
    logic        o_rillegal_1;
    logic        o_illegalWrite_1;
    logic        o_redirectValid_1;
    logic        i_redirectReady_1 = 1'b0;
    logic [31:0] o_redirectPc_32;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_ill;
        logic        exp_rill;
    } vec_t;

    vec_t tbl[12];
    vec_t sb[$];
    vec_t cur;

    csr_regfile #(.P_MTVEC_RESET(32'h0000_0100)) dut (
        .clk(clk), .rstn(rstn),
        .i_wvalid(i_wvalid), .o_wready(o_wready),
        .i_waddr_12(i_waddr_12), .i_wdata_32(i_wdata_32),
        .i_isEnv_1(i_isEnv_1), .i_isMret_1(i_isMret_1),
        .i_pc_32(i_pc_32), .i_retire_1(i_retire_1),
        .i_raddr_12(i_raddr_12), .o_rdata_32(o_rdata_32),
        .o_rillegal_1(o_rillegal_1),
        .o_illegalWrite_1(o_illegalWrite_1),
        .o_redirectValid_1(o_redirectValid_1),
        .i_redirectReady_1(i_redirectReady_1),
        .o_redirectPc_32(o_redirectPc_32)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic rd(input string name, input logic [11:0] a,
                      input logic [31:0] exp);
        i_raddr_12 = a;
        #1;
        chk(name, o_rdata_32, exp);
    endtask

    task automatic do_write(input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        i_wvalid = 1'b1;
        i_waddr_12 = a;
        i_wdata_32 = d;
        @(posedge clk);
        #1;
        i_wvalid = 1'b0;
    endtask

    task automatic do_env(input logic mret, input logic [31:0] pc);
        @(negedge clk);
        i_wvalid = 1'b1;
        i_isEnv_1 = ~mret;
        i_isMret_1 = mret;
        i_pc_32 = pc;
        i_waddr_12 = 12'h340;
        i_wdata_32 = 32'h0;
        @(posedge clk);
        #1;
        i_wvalid = 1'b0;
        i_isEnv_1 = 1'b0;
        i_isMret_1 = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{12'h340, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b0};
        tbl[1]  = '{12'h341, 32'h0000_1235, 32'h0000_1234, 1'b0, 1'b0};
        tbl[2]  = '{12'h304, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0};
        tbl[3]  = '{12'h305, 32'h0000_0083, 32'h0000_0080, 1'b0, 1'b0};
        tbl[4]  = '{12'h342, 32'h0000_0007, 32'h0000_0007, 1'b0, 1'b0};
        tbl[5]  = '{12'h343, 32'h0000_ABCD, 32'h0000_ABCD, 1'b0, 1'b0};
        tbl[6]  = '{12'h300, 32'hFFFF_FFFF, 32'h0000_1888, 1'b0, 1'b0};
        tbl[7]  = '{12'h300, 32'h0000_0008, 32'h0000_1808, 1'b0, 1'b0};
        tbl[8]  = '{12'h301, 32'h0000_0000, 32'h4000_0100, 1'b1, 1'b0};
        tbl[9]  = '{12'h7C0, 32'h0000_0123, 32'h0000_0000, 1'b1, 1'b1};
        tbl[10] = '{12'h344, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0};
        tbl[11] = '{12'hF14, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0};

        #12;
        rd("rst_mtvec", 12'h305, 32'h0000_0100);
        rd("rst_mstatus", 12'h300, 32'h0000_1800);
        rd("rst_mcause", 12'h342, 32'h0);
        chk("rst_valid", {31'd0, o_redirectValid_1}, 32'd0);
        chk("rst_pc", o_redirectPc_32, 32'd0);
        chk("rst_illw", {31'd0, o_illegalWrite_1}, 32'd0);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_wready", {31'd0, o_wready}, 32'd1);
        rd("rst_misa", 12'h301, 32'h4000_0100);

        for (int i = 0; i < 12; i++) begin
            do_write(tbl[i].addr, tbl[i].wdata);
            sb.push_back(tbl[i]);
            cur = sb.pop_front();
            chk($sformatf("illw[%0d]", i), {31'd0, o_illegalWrite_1},
                {31'd0, cur.exp_ill});
            rd($sformatf("rd[%0d]", i), cur.addr, cur.exp_rd);
            chk($sformatf("rill[%0d]", i), {31'd0, o_rillegal_1},
                {31'd0, cur.exp_rill});
            @(posedge clk);
            #1;
            chk($sformatf("illw_drop[%0d]", i),
                {31'd0, o_illegalWrite_1}, 32'd0);
        end
        rd("misa_kept", 12'h301, 32'h4000_0100);

        do_env(1'b0, 32'h0000_0200);
        chk("ec_valid", {31'd0, o_redirectValid_1}, 32'd1);
        chk("ec_pc", o_redirectPc_32, 32'h0000_0080);
        chk("ec_wready", {31'd0, o_wready}, 32'd0);
        rd("ec_mepc", 12'h341, 32'h0000_0200);
        rd("ec_mcause", 12'h342, 32'd11);
        rd("ec_mtval", 12'h343, 32'd0);
        rd("ec_mstatus", 12'h300, 32'h0000_1880);
        rd("ec_mscratch", 12'h340, 32'hDEAD_BEEF);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            i_wvalid = 1'b1;
            i_waddr_12 = 12'h340;
            i_wdata_32 = 32'h0;
            @(posedge clk);
            #1;
            chk($sformatf("hold_wready[%0d]", i), {31'd0, o_wready}, 32'd0);
            chk($sformatf("hold_valid[%0d]", i),
                {31'd0, o_redirectValid_1}, 32'd1);
            chk($sformatf("hold_pc[%0d]", i), o_redirectPc_32, 32'h80);
        end
        @(negedge clk);
        i_wvalid = 1'b0;
        i_redirectReady_1 = 1'b1;
        @(posedge clk);
        #1;
        i_redirectReady_1 = 1'b0;
        chk("ec_done_valid", {31'd0, o_redirectValid_1}, 32'd0);
        chk("ec_done_wready", {31'd0, o_wready}, 32'd1);
        rd("blocked_write", 12'h340, 32'hDEAD_BEEF);

        do_env(1'b1, 32'h0);
        chk("mr_valid", {31'd0, o_redirectValid_1}, 32'd1);
        chk("mr_pc", o_redirectPc_32, 32'h0000_0200);
        rd("mr_mstatus", 12'h300, 32'h0000_1888);
        @(negedge clk);
        i_redirectReady_1 = 1'b1;
        @(posedge clk);
        #1;
        i_redirectReady_1 = 1'b0;
        chk("mr_done", {31'd0, o_wready}, 32'd1);

        do_write(12'hB00, 32'hFFFF_FFFF);
        do_write(12'hB80, 32'h0);
        rd("cyc_lo_hold", 12'hB00, 32'hFFFF_FFFF);
        rd("cyc_hi_set", 12'hB80, 32'h0);
        @(posedge clk);
        #1;
        rd("cyc_lo_wrap", 12'hB00, 32'h0);
        rd("cyc_hi_carry", 12'hB80, 32'h1);
        rd("cycleh_alias", 12'hC80, 32'h1);

        i_retire_1 = 1'b1;
        do_write(12'hB02, 32'h5);
        i_retire_1 = 1'b0;
        rd("ret_wr", 12'hB02, 32'h5);
        rd("ret_hi", 12'hB82, 32'h0);
        @(negedge clk);
        i_retire_1 = 1'b1;
        @(posedge clk);
        #1;
        i_retire_1 = 1'b0;
        rd("ret_inc", 12'hB02, 32'h6);
        rd("instret_alias", 12'hC02, 32'h6);

        do_env(1'b0, 32'h0000_0300);
        chk("rr_valid", {31'd0, o_redirectValid_1}, 32'd1);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("rr_valid0", {31'd0, o_redirectValid_1}, 32'd0);
        chk("rr_wready", {31'd0, o_wready}, 32'd1);
        chk("rr_pc", o_redirectPc_32, 32'd0);
        rd("rr_mtvec", 12'h305, 32'h0000_0100);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
